// File: rtl/fpu_adder_pipe.sv
// Three-stage pipelined IEEE-754 adder/subtractor with flush-to-zero, round-to-nearest-even,
// special-value bypass and a single global stall driven by output backpressure.
module fpu_adder_pipe #(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   invalid
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 4;                       // hidden, fraction, guard, round, sticky
  localparam int SW = MAN_W + 5;                       // MW plus carry
  localparam int XW = EXP_W + $clog2(MW) + 2;          // signed working exponent
  localparam logic signed [XW-1:0] EMAX_X = XW'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic en;
  logic v1, v2, v3;

  // stage 1 registers
  logic             s1_sp, s1_inv, s1_sign, s1_sub;
  logic [W-1:0]     s1_res;
  logic [EXP_W-1:0] s1_exp;
  logic [MW-1:0]    s1_m1, s1_m2;
  // stage 2 registers
  logic             s2_sp, s2_inv, s2_sign;
  logic [W-1:0]     s2_res;
  logic [EXP_W-1:0] s2_exp;
  logic [SW-1:0]    s2_sum;
  // stage 3 (output) registers
  logic [W-1:0]     s3_res;
  logic             s3_ovf, s3_unf, s3_inv;

  assign en        = !v3 || out_ready;
  assign in_ready  = en;
  assign out_valid = v3;
  assign result    = v3 ? s3_res : '0;
  assign overflow  = v3 & s3_ovf;
  assign underflow = v3 & s3_unf;
  assign invalid   = v3 & s3_inv;

  // ---------------- unpack / classify / align ----------------
  logic             sa, sb, za, zb, ia, ib, na, nb, a_big;
  logic [EXP_W-1:0] ea, eb, e1, e2;
  logic [MAN_W-1:0] fa, fb, f1, f2;
  logic [XW-1:0]    diff, sh;
  logic [2*MW-1:0]  wide;
  logic [MW-1:0]    m1_0, m2_0;
  logic             sp_0, inv_0;
  logic [W-1:0]     res_0;

  // NOTE: combinational blocks use blocking '=' and assign every output a default first,
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    sa = a[W-1];
    ea = a[W-2:MAN_W];
    fa = a[MAN_W-1:0];
    sb = b[W-1] ^ op;
    eb = b[W-2:MAN_W];
    fb = b[MAN_W-1:0];
    za = (ea == '0);
    zb = (eb == '0);
    ia = (ea == '1) && (fa == '0);
    ib = (eb == '1) && (fb == '0);
    na = (ea == '1) && (fa != '0);
    nb = (eb == '1) && (fb != '0);

    a_big = {ea, fa} >= {eb, fb};
    e1    = a_big ? ea : eb;
    e2    = a_big ? eb : ea;
    f1    = a_big ? fa : fb;
    f2    = a_big ? fb : fa;
    diff  = XW'(e1) - XW'(e2);
    sh    = (diff >= XW'(MW)) ? XW'(MW) : diff;
    m1_0  = {1'b1, f1, 3'b000};
    wide  = {1'b1, f2, 3'b000, {MW{1'b0}}} >> sh;
    m2_0  = wide[2*MW-1:MW] | {{(MW-1){1'b0}}, |wide[MW-1:0]};

    sp_0  = 1'b1;
    inv_0 = 1'b0;
    res_0 = '0;
    if (na || nb || (ia && ib && (sa != sb))) begin
      res_0 = QNAN;
      inv_0 = 1'b1;
    end else if (ia)       res_0 = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (ib)           res_0 = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (za && zb)     res_0 = {sa & sb, {(W-1){1'b0}}};
    else if (za)           res_0 = {sb, eb, fb};
    else if (zb)           res_0 = {sa, ea, fa};
    else                   sp_0  = 1'b0;
  end

  // ---------------- add ----------------
  logic [SW-1:0] sum_1;
  always_comb begin
    sum_1 = s1_sub ? ({1'b0, s1_m1} - {1'b0, s1_m2}) : ({1'b0, s1_m1} + {1'b0, s1_m2});
  end

  // ---------------- normalise / round / pack ----------------
  function automatic logic [XW-1:0] lzc(input logic [MW-1:0] v);
    lzc = XW'(MW);
    for (int i = 0; i < MW; i++)
      if (v[i]) lzc = XW'(MW - 1 - i);
  endfunction

  logic [XW-1:0]           lz;
  logic [MW-1:0]           norm;
  logic signed [XW-1:0]    ex, ex2;
  logic                    up;
  logic [MAN_W+1:0]        mant_r;
  logic [MAN_W-1:0]        frac;
  logic [W-1:0]            res_2;
  logic                    ovf_2, unf_2, inv_2;

  always_comb begin
    lz = lzc(s2_sum[MW-1:0]);
    if (s2_sum[SW-1]) begin
      norm = {s2_sum[SW-1:2], s2_sum[1] | s2_sum[0]};
      ex   = XW'(s2_exp) + XW'(1);
    end else begin
      norm = s2_sum[MW-1:0] << lz;
      ex   = XW'(s2_exp) - lz;
    end
    up     = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r = {1'b0, norm[MW-1:3]} + {{(MAN_W+1){1'b0}}, up};
    if (mant_r[MAN_W+1]) begin
      frac = mant_r[MAN_W:1];
      ex2  = ex + XW'(1);
    end else begin
      frac = mant_r[MAN_W-1:0];
      ex2  = ex;
    end

    res_2 = {s2_sign, ex2[EXP_W-1:0], frac};
    ovf_2 = 1'b0;
    unf_2 = 1'b0;
    inv_2 = 1'b0;
    if (s2_sp) begin
      res_2 = s2_res;
      inv_2 = s2_inv;
    end else if (ex2 >= EMAX_X) begin
      res_2 = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_2 = 1'b1;
    end else if (ex2[XW-1] || (ex2 == '0)) begin
      res_2 = {s2_sign, {(W-1){1'b0}}};
      unf_2 = 1'b1;
    end
  end

  // ---------------- registers ----------------
  // NOTE: sequential blocks use non-blocking '<=' so every stage samples the previous
  // stage's value from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (en) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  // NOTE: payload registers have no reset; their contents are ignored until the matching
  // valid bit is set, and the outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_sp   <= sp_0;
      s1_res  <= res_0;
      s1_inv  <= inv_0;
      s1_sign <= a_big ? sa : sb;
      s1_sub  <= sa != sb;
      s1_exp  <= e1;
      s1_m1   <= m1_0;
      s1_m2   <= m2_0;

      // an exact cancellation is forced to +0 here, before normalisation sees it
      s2_sp   <= s1_sp || (sum_1 == '0);
      s2_res  <= s1_sp ? s1_res : '0;
      s2_inv  <= s1_sp & s1_inv;
      s2_sign <= s1_sign;
      s2_exp  <= s1_exp;
      s2_sum  <= sum_1;

      s3_res  <= res_2;
      s3_ovf  <= ovf_2;
      s3_unf  <= unf_2;
      s3_inv  <= inv_2;
    end
  end

endmodule

// File: tb/tb_fpu_adder_pipe.sv
// Bench for fpu_adder_pipe: directed corner cases plus random traffic scored against a
// model built on the simulator's native double arithmetic, with FTZ/flag rules layered on top.
module tb_fpu_adder_pipe;

  localparam logic [63:0] QNAN = 64'h7FF8000000000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, op, out_valid, out_ready;
  logic [63:0] a, b, result;
  logic        overflow, underflow, invalid;

  logic        sp_in_valid, sp_in_ready, sp_opsel, sp_out_valid;
  logic [31:0] sp_a, sp_b, sp_result;
  logic        sp_ovf, sp_unf, sp_inv;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        op;
    logic [63:0] r;
    logic [2:0]  f;   // {overflow, underflow, invalid}
  } txn_t;

  txn_t stim_q[$];
  txn_t exp_q[$];

  always #5 clk = ~clk;

  fpu_adder_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .underflow(underflow), .invalid(invalid)
  );

  fpu_adder_pipe #(.EXP_W(8), .MAN_W(23)) u_dut_sp (
    .clk(clk), .rst(rst), .in_valid(sp_in_valid), .in_ready(sp_in_ready),
    .a(sp_a), .b(sp_b), .op(sp_opsel), .out_valid(sp_out_valid), .out_ready(1'b1),
    .result(sp_result), .overflow(sp_ovf), .underflow(sp_unf), .invalid(sp_inv)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic is_nan(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
  endfunction

  function automatic logic [63:0] ftz(input logic [63:0] x);
    return (x[62:52] == 11'd0) ? {x[63], 63'd0} : x;
  endfunction

  function automatic void ref_add(input logic [63:0] x, input logic [63:0] y, input logic o,
                                  output logic [63:0] r, output logic [2:0] f);
    logic [63:0] xa, ya, s;
    xa = ftz(x);
    ya = ftz(y);
    ya[63] = ya[63] ^ o;
    f = 3'b000;
    if (is_nan(xa) || is_nan(ya)) begin
      r = QNAN;
      f = 3'b001;
      return;
    end
    s = $realtobits($bitstoreal(xa) + $bitstoreal(ya));
    r = s;
    if (is_nan(s)) begin
      r = QNAN;
      f = 3'b001;
    end else if (s[62:52] == 11'h7FF && xa[62:52] != 11'h7FF && ya[62:52] != 11'h7FF) begin
      f = 3'b100;
    end else if (s[62:52] == 11'd0 && s[51:0] != 52'd0) begin
      r = {s[63], 63'd0};
      f = 3'b010;
    end
  endfunction

  // ---------------- stimulus generation ----------------
  function automatic logic [63:0] rnd_special();
    logic [63:0] t;
    t = {$urandom, $urandom};
    case ($urandom_range(0, 4))
      0: return {t[63], 63'd0};
      1: return {t[63], 11'h7FF, 52'd0};
      2: return {t[63], 11'h7FF, t[51:1], 1'b1};
      3: return {t[63], 11'd0, t[51:0]};
      default: return {t[63], 11'h3FF, 52'd0};
    endcase
  endfunction

  function automatic logic [10:0] clamp_exp(input int e);
    if (e < 1) return 11'd1;
    if (e > 2046) return 11'd2046;
    return 11'(e);
  endfunction

  task automatic push_directed(input logic [63:0] x, input logic [63:0] y, input logic o,
                               input logic [63:0] r, input logic [2:0] f);
    txn_t t;
    t.a = x; t.b = y; t.op = o; t.r = r; t.f = f;
    stim_q.push_back(t);
  endtask

  task automatic push_random();
    txn_t t;
    logic [63:0] ra, rb;
    int ea, eb, d;
    ra = {$urandom, $urandom};
    rb = {$urandom, $urandom};
    case ($urandom_range(0, 9))
      0:       ea = $urandom_range(2040, 2046);
      1:       ea = $urandom_range(1, 4);
      default: ea = $urandom_range(1, 2046);
    endcase
    case ($urandom_range(0, 3))
      0: begin d = $urandom_range(0, 6);   eb = ea + d - 3;  end
      1: begin d = $urandom_range(0, 120); eb = ea + d - 60; end
      2: eb = $urandom_range(1, 2046);
      default: begin eb = ea; rb[51:0] = ra[51:0] ^ 52'($urandom_range(0, 255)); end
    endcase
    t.a = {ra[63], clamp_exp(ea), ra[51:0]};
    t.b = {rb[63], clamp_exp(eb), rb[51:0]};
    if ($urandom_range(0, 15) == 0) t.a = rnd_special();
    if ($urandom_range(0, 15) == 0) t.b = rnd_special();
    t.op = 1'($urandom_range(0, 1));
    ref_add(t.a, t.b, t.op, t.r, t.f);
    stim_q.push_back(t);
  endtask

  // ---------------- driver / scoreboard loop ----------------
  // in_mode: 0 back-to-back, 1 random gaps.  out_mode: 0 always ready, 1 random,
  // 2 hold ready low for 5 cycles from the first out_valid.
  task automatic run(input int in_mode, input int out_mode, input int budget);
    txn_t t, e;
    int cyc = 0;
    int stall_left = 0;
    bit seen_first = 0;
    bit prev_hold = 0;
    logic [63:0] prev_r = '0;
    while ((stim_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (stim_q.size() > 0 && (in_mode == 0 || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        a = stim_q[0].a; b = stim_q[0].b; op = stim_q[0].op;
      end else begin
        in_valid = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = 1'($urandom_range(0, 1));
      end
      if (out_mode == 2 && !seen_first && out_valid) begin
        seen_first = 1;
        stall_left = 5;
      end
      case (out_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 2) != 0);
        default: begin
          out_ready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
      endcase
      #1;
      if (prev_hold) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_result", result, prev_r);
      end
      if (out_valid && !out_ready) check("stall_in_ready", in_ready, 1'b0);
      if (!out_valid) begin
        check("idle_result", result, 64'd0);
        check("idle_flags", {overflow, underflow, invalid}, 64'd0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("result a=%h b=%h op=%0d", e.a, e.b, e.op), result, e.r);
          check($sformatf("flags a=%h b=%h op=%0d", e.a, e.b, e.op),
                {overflow, underflow, invalid}, e.f);
        end
      end
      if (in_valid && in_ready) begin
        t = stim_q.pop_front();
        exp_q.push_back(t);
      end
      prev_hold = out_valid && !out_ready;
      prev_r    = result;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_complete", stim_q.size() + exp_q.size(), 0);
    stim_q.delete();
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      check("idle_out_valid", out_valid, 1'b0);
      check("idle_in_ready", in_ready, 1'b1);
    end
  endtask

  task automatic sp_run(input logic [31:0] x, input logic [31:0] y, input logic o,
                        input logic [31:0] want, input string tag);
    int n = 0;
    @(negedge clk);
    sp_in_valid = 1'b1; sp_a = x; sp_b = y; sp_opsel = o;
    @(negedge clk);
    sp_in_valid = 1'b0;
    while (!sp_out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, sp_out_valid, 1'b1);
    check(tag, sp_result, want);
    check({tag, "_flags"}, {sp_ovf, sp_unf, sp_inv}, 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = 1'b0;
    sp_in_valid = 1'b0; sp_a = '0; sp_b = '0; sp_opsel = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 64'd0);
    check("rst_flags", {overflow, underflow, invalid}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);

    // latency: capture edge plus two more edges
    @(negedge clk);
    in_valid = 1'b1; a = 64'h3FF0000000000000; b = 64'h4000000000000000; op = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
      #1;
      if (out_valid) break;
    end
    check("latency", lat, 3);
    check("latency_result", result, 64'h4008000000000000);
    idle(3);

    push_directed(64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 64'h4008000000000000, 3'b000);
    push_directed(64'h3FF0000000000000, 64'h3FF0000000000000, 1'b1, 64'h0000000000000000, 3'b000);
    push_directed(64'h3FF0000000000000, 64'h3CA0000000000000, 1'b0, 64'h3FF0000000000000, 3'b000);
    push_directed(64'h3FF0000000000000, 64'h3CB8000000000000, 1'b0, 64'h3FF0000000000002, 3'b000);
    push_directed(64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 1'b0, 64'h7FF0000000000000, 3'b100);
    push_directed(64'h7FF0000000000000, 64'h7FF0000000000000, 1'b1, 64'h7FF8000000000000, 3'b001);
    push_directed(64'h0020000000000000, 64'h001FFFFFFFFFFFFF, 1'b1, 64'h0000000000000000, 3'b010);
    push_directed(64'h0000000000000001, 64'h3FF0000000000000, 1'b0, 64'h3FF0000000000000, 3'b000);
    push_directed(64'h8000000000000000, 64'h8000000000000000, 1'b0, 64'h8000000000000000, 3'b000);
    push_directed(64'h0000000000000000, 64'h0000000000000000, 1'b1, 64'h0000000000000000, 3'b000);
    push_directed(64'hFFF0000000000000, 64'h3FF0000000000000, 1'b1, 64'hFFF0000000000000, 3'b000);
    push_directed(64'h7FF0000000000001, 64'h3FF0000000000000, 1'b0, 64'h7FF8000000000000, 3'b001);
    push_directed(64'hFFEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 1'b1, 64'hFFF0000000000000, 3'b100);
    run(0, 0, 200);

    repeat (200) push_random();
    run(0, 0, 2000);
    repeat (300) push_random();
    run(1, 1, 6000);

    repeat (6) push_random();
    run(0, 2, 200);
    idle(5);

    // reset with three operations in flight
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 64'h3FF0000000000000; b = 64'h4000000000000000; op = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre_rst_out_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_result", result, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(8);

    sp_run(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, "sp_add");
    sp_run(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, "sp_sub");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fpu_adder_pipe.md
# fpu_adder_pipe

Parametrised, pipelined IEEE-754 floating-point adder/subtractor with valid/ready handshakes on input and output. It generalises the FPU's combinational 64-bit adder to any exponent/mantissa width and adds a subtract mode, round-to-nearest-even, special-value handling and backpressure. It sits between the FPU operand issue logic and the result writeback, and accepts one operation per cycle when not stalled.

## Interface
- EXP_W, 11, exponent field width (≥3)
- MAN_W, 52, stored fraction width (≥4); word width W = 1+EXP_W+MAN_W
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands a, b, op present
- in_ready  out  1  block accepts operands this cycle
- a  in  W  operand A {sign, exponent, fraction}
- b  in  W  operand B
- op  in  1  0 = a+b, 1 = a−b (b sign inverted at entry)
- out_valid  out  1  result and flags valid
- out_ready  in  1  downstream accepts result
- result  out  W  rounded sum
- overflow  out  1  finite operands produced ±inf
- underflow  out  1  nonzero exact result flushed to zero
- invalid  out  1  result is canonical NaN from inf−inf or NaN input

## Operation
- Transfer at input when in_valid && in_ready; at output when out_valid && out_ready.
- Stage 1 (unpack/align): inputs with exponent 0 are treated as ±0 (flush-to-zero, no flag). Classify zero/inf/NaN. Swap so operand 1 has the larger magnitude (exponent, then fraction). Prepend hidden 1. Right-shift operand 2 by the exponent difference into MAN_W+4 bits (hidden, fraction, guard, round, sticky); shifts ≥ MAN_W+3 leave only sticky = OR of shifted-out bits.
- Stage 2 (add): effective subtract when signs differ. Sum width MAN_W+5 (carry bit). Result sign = operand-1 sign. An exact zero difference gives +0; −0 + −0 gives −0.
- Stage 3 (normalise/round/pack): on carry, shift right 1 (sticky absorbs) and exponent+1; otherwise leading-zero count, shift left, exponent−count. Round to nearest, ties to even, using guard/round/sticky; rounding carry-out renormalises and increments exponent. Exponent ≥ 2^EXP_W−1 → ±inf, overflow=1. Exponent ≤ 0 → ±0, underflow=1.
- Specials (bypass arithmetic, carried through pipeline): any NaN input or inf + (−inf) → canonical NaN {0, all-ones exp, fraction MSB 1, rest 0}, invalid=1; inf ± finite → that inf; zero ± x → x, with sign rules above.
- Flags are mutually exclusive and valid only with out_valid.

## Timing
- Three register stages; latency exactly 3 cycles from input transfer to out_valid when out_ready stays high. Throughput 1/cycle.
- Global advance enable = !out_valid || out_ready. in_ready = enable (combinational from out_valid/out_ready only, not from in_valid). When enable is low, all stage registers, valids and output hold; result must not change while out_valid && !out_ready.
- Bubbles propagate as valid=0; data registers of invalid stages are don't-care but outputs are gated: result, flags = 0 when out_valid = 0.
- Reset: all stage valids 0; out_valid=0, result=0, overflow=underflow=invalid=0; in_ready=1 from the first cycle after reset deasserts. Reset mid-operation discards all in-flight operations; none emerge afterwards.
- Simultaneous input transfer and output transfer in the same cycle is supported with no bubble.

## Test plan
- Defaults, out_ready=1: a=0x3FF0000000000000 (1.0), b=0x4000000000000000 (2.0), op=0 → 3 cycles later result=0x4008000000000000, flags 0; op=1 with a=b=1.0 → 0x0000000000000000.
- Rounding: 1.0 + 0x3CA0000000000000 (2^−53) → 0x3FF0000000000000 (tie to even); 1.0 + 0x3CB8000000000000 → 0x3FF0000000000002.
- Overflow/specials: 0x7FEFFFFFFFFFFFFF + 0x7FEFFFFFFFFFFFFF → 0x7FF0000000000000, overflow=1; 0x7FF0000000000000 − 0x7FF0000000000000 → 0x7FF8000000000000, invalid=1.
- Underflow: 0x0020000000000000 − 0x001FFFFFFFFFFFFF → 0x0000000000000000, underflow=1; denormal input 0x0000000000000001 + 1.0 → 1.0, no flags.
- Backpressure: stream 6 back-to-back ops, drop out_ready for 5 cycles after first out_valid → in_ready low during stall, result stable, all 6 results in order, none lost or duplicated.
- Reset mid-stream with 3 ops in flight → out_valid=0 immediately, no stale results after release; parameter sweep EXP_W=8, MAN_W=23: 0x3F800000 + 0x40000000 → 0x40400000.
